usb_hid_keyq: RTL
=================

Name: usb_hid_keyq

Overview:
- Successor to the flat USB HID register window: converts HID host outputs into a CPU-readable key event FIFO plus saturating mouse accumulators and an interrupt.
- Sits between usb_hid_host outputs and the 6502 I/O decoder. All inputs are already synchronised to clk_i; report_i is a single-cycle pulse.
- Key-slot count and FIFO depth are parametrised.

Parameters:
- NUM_KEYS, 4, keycode slots in keys_i (1..6).
- FIFO_DEPTH, 8, key event entries; power of two, 2..64.
- REPEAT_DELAY, 12500000, clk_i cycles before first typematic repeat (KEY_REPEAT_EN only).
- REPEAT_PERIOD, 2500000, clk_i cycles between later repeats (KEY_REPEAT_EN only).

Ports:
- clk_i  in  1  system clock. Single clock domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- cs_i  in  1  chip select. Access side effects fire once, on the first cycle of each cs_i assertion.
- r_w_n_i  in  1  1 = read, 0 = write.
- reg_addr_i  in  4  register address.
- data_i  in  8  write data.
- data_o  out  8  read data, combinational from reg_addr_i.
- irq_o  out  1  registered interrupt, active high.
- report_i  in  1  report-received pulse.
- typ_i  in  2  device type: 0 none, 1 keyboard, 2 mouse, 3 gamepad.
- conerr_i  in  1  connection error.
- key_mod_i  in  8  modifier byte.
- keys_i  in  8*NUM_KEYS  keycodes; slot i is [8i+7:8i].
- mouse_btn_i  in  8  mouse buttons.
- mouse_dx_i, mouse_dy_i  in  8 each  signed mouse deltas.

Behaviour:
- Register map (R = read, W = write):
  - 0 R status: {irq_en, conerr_i, typ_i[1:0], ovf, mouse_new, full, nonempty}.
  - 1 R head keycode; read pops the FIFO. Reading an empty FIFO returns 0 with no state change.
  - 2 R head modifiers, no pop.
  - 3 R FIFO count, zero-extended.
  - 4 R mouse_btn_i.
  - 5 R acc_dx; read clears acc_dx and mouse_new.
  - 6 R acc_dy; read clears acc_dy.
  - 7 W control: bit0 irq_en, bit1 flush FIFO, bit2 clear ovf. Reads of 7 and of 8–15 return 0.
- Reset values: FIFO empty, count 0, ovf 0, mouse_new 0, acc_dx = acc_dy = 0, irq_en 0, irq_o 0, prev_keys all 0, FSM in IDLE.
- Key FSM:
  - IDLE: on report_i with typ_i == 1, snapshot keys_i and key_mod_i, go to SCAN with idx 0.
  - If every slot equals 0x01 (rollover error), the report is discarded and the FSM stays in IDLE.
  - SCAN: one slot per cycle. A slot k is pushed as {mod, k} when k >= 0x04 and k is not in prev_keys.
  - After slot NUM_KEYS-1: prev_keys <= snapshot, return to IDLE. Latency is NUM_KEYS+1 cycles from report_i to IDLE.
  - A report_i arriving in SCAN sets a one-deep pending flag; on return to IDLE a new scan starts immediately with the current inputs. Further reports while pending are dropped.
  - Duplicate keycodes within one report: only the first occurrence is pushed.
- FIFO:
  - Push when full: entry dropped, ovf set (sticky until control bit2).
  - Push and pop in the same cycle: both take effect, count unchanged. When the FIFO is empty, the push happens and the pop returns 0.
  - Flush clears entries and count only; it does not affect ovf.
- Mouse: on report_i with typ_i == 2:
  - acc <= sat8(acc + delta), signed, clamped to [-128, 127].
  - mouse_new is set.
  - If a clear-by-read and an update land in the same cycle, the result is the new delta alone.
- Disconnect: while typ_i == 0, prev_keys is held at 0 so keys re-press after reconnect. FIFO contents are kept.
- irq_o (registered, one cycle after the cause): irq_o <= irq_en & (nonempty | mouse_new).
- Mid-operation reset: every state returns to its reset value immediately (asynchronous).

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - The most recently pushed keycode is tracked.
  - While it stays present in every subsequent snapshot, it is re-pushed with the current modifiers REPEAT_DELAY cycles after the original push, then every REPEAT_PERIOD cycles.
  - The repeat is cancelled by its release, by any new key push, or by typ_i != 1.
  - Counter width is $clog2 of the larger of the two parameters.
- Undefined: no repeat logic; REPEAT_DELAY and REPEAT_PERIOD are unused.

Test Plan:
- Report with keys {0x04,0,0,0}, mod 0x02 -> count 1; reg2 = 0x02; reg1 = 0x04; count then 0.
- Report {0x04,0x05,0,0} following {0x04,0,0,0} -> only 0x05 queued. A second report arriving during SCAN is processed afterwards via the pending flag.
- FIFO_DEPTH+1 distinct new keys -> full = 1, ovf = 1, last key dropped. Control write 0x04 clears ovf; flush empties the FIFO.
- Rollover report {0x01,0x01,0x01,0x01} -> nothing queued, prev_keys unchanged.
- Mouse dx +100 then +100 -> acc_dx = 127. Read reg5 in the same cycle as a dx = -5 report -> acc_dx = -5 (0xFB).
- irq_en = 1, one key pushed -> irq_o rises one cycle after the push and falls one cycle after the pop. With KEY_REPEAT_EN, REPEAT_DELAY = 10 and REPEAT_PERIOD = 4 -> re-pushes at +10, +14, +18 cycles until the key is released.

Source files
------------

// File: rtl/usb_hid_keyq.sv
// HID host to CPU bridge: key event FIFO, saturating mouse accumulators, interrupt.
// Optional typematic repeat is compiled in with `define KEY_REPEAT_EN.
module usb_hid_keyq #(
    parameter int NUM_KEYS      = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cs_i,
    input  logic                  r_w_n_i,
    input  logic [3:0]            reg_addr_i,
    input  logic [7:0]            data_i,
    output logic [7:0]            data_o,
    output logic                  irq_o,
    input  logic                  report_i,
    input  logic [1:0]            typ_i,
    input  logic                  conerr_i,
    input  logic [7:0]            key_mod_i,
    input  logic [8*NUM_KEYS-1:0] keys_i,
    input  logic [7:0]            mouse_btn_i,
    input  logic [7:0]            mouse_dx_i,
    input  logic [7:0]            mouse_dy_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    typedef enum logic {ST_IDLE, ST_SCAN} state_e;

    function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] s;
        s = $signed({a[7], a}) + $signed({b[7], b});
        if (s > 9'sd127)       return 8'h7F;
        else if (s < -9'sd128) return 8'h80;
        else                   return s[7:0];
    endfunction

    // Bus decode: side effects only on the first cycle of a cs_i assertion
    logic cs_q, access, rd_en, wr_en, ctrl_wr, pop_req, clr_dx, clr_dy, flush;
    assign access  = cs_i & ~cs_q;
    assign rd_en   = access & r_w_n_i;
    assign wr_en   = access & ~r_w_n_i;
    assign ctrl_wr = wr_en && (reg_addr_i == 4'd7);
    assign flush   = ctrl_wr & data_i[1];
    assign pop_req = rd_en && (reg_addr_i == 4'd1);
    assign clr_dx  = rd_en && (reg_addr_i == 4'd5);
    assign clr_dy  = rd_en && (reg_addr_i == 4'd6);

    logic unused_data;
    assign unused_data = ^data_i[7:3];

    logic [NUM_KEYS-1:0][7:0] keys_in;
    assign keys_in = keys_i;

    // Key scan state
    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_KEYS-1:0][7:0] snap_q, snap_d;
    logic [NUM_KEYS-1:0][7:0] prev_q, prev_d;
    logic [7:0]               snap_mod_q, snap_mod_d;
    logic                     pend_q, pend_d;
    logic                     rollover, seen, scan_push, scan_start;
    logic [7:0]               cur_key;

    always_comb begin
        rollover = 1'b1;
        for (int i = 0; i < NUM_KEYS; i++)
            if (keys_in[i] != 8'h01) rollover = 1'b0;
    end

    assign cur_key = snap_q[idx_q];

    // A slot is new if absent from the last report and not earlier in this one
    always_comb begin
        seen = 1'b0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            if (prev_q[j] == cur_key) seen = 1'b1;
            if (j < int'(idx_q) && snap_q[j] == cur_key) seen = 1'b1;
        end
    end

    assign scan_push = (state_q == ST_SCAN) && (cur_key >= 8'h04) && !seen;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        snap_mod_d = snap_mod_q;
        pend_d     = pend_q;
        prev_d     = prev_q;
        scan_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (report_i || pend_q) begin
                    pend_d = 1'b0;
                    if (typ_i == 2'd1 && !rollover) begin
                        scan_start = 1'b1;
                        snap_d     = keys_in;
                        snap_mod_d = key_mod_i;
                        idx_d      = '0;
                        state_d    = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (report_i && typ_i == 2'd1) pend_d = 1'b1;
                if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
                    prev_d  = snap_q;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (typ_i == 2'd0) prev_d = '0;
    end

    // Typematic repeat source
    logic        rpt_push;
    logic [15:0] rpt_data;

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic             rpt_act_q, rpt_act_d, rpt_held;
    logic [7:0]       rpt_key_q, rpt_key_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    always_comb begin
        rpt_held = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (keys_in[i] == rpt_key_q) rpt_held = 1'b1;
    end

    assign rpt_push = rpt_act_q && (rpt_cnt_q == '0) && (typ_i == 2'd1) && !scan_push;
    assign rpt_data = {key_mod_i, rpt_key_q};

    always_comb begin
        rpt_act_d = rpt_act_q;
        rpt_key_d = rpt_key_q;
        rpt_cnt_d = rpt_cnt_q;
        if (rpt_act_q)
            rpt_cnt_d = (rpt_cnt_q == '0) ? RPT_W'(REPEAT_PERIOD - 1) : rpt_cnt_q - 1'b1;
        if ((scan_start && !rpt_held) || typ_i != 2'd1) rpt_act_d = 1'b0;
        // Any fresh push retargets the repeat to that key
        if (scan_push) begin
            rpt_act_d = 1'b1;
            rpt_key_d = cur_key;
            rpt_cnt_d = RPT_W'(REPEAT_DELAY - 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rpt_act_q <= 1'b0;
            rpt_key_q <= 8'h00;
            rpt_cnt_q <= '0;
        end else begin
            rpt_act_q <= rpt_act_d;
            rpt_key_q <= rpt_key_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    assign rpt_push = 1'b0;
    assign rpt_data = 16'h0000;
`endif

    // Key event FIFO
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, pop, push_req, push_ok;
    logic [15:0]      push_data, head;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = pop_req && !empty;
    assign push_req  = scan_push | rpt_push;
    assign push_data = scan_push ? {snap_mod_q, cur_key} : rpt_data;
    assign push_ok   = push_req && (!full || pop) && !flush;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end
        if (ctrl_wr && data_i[2]) ovf_d = 1'b0;
        if (push_req && !push_ok && !flush) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    // Mouse accumulators; a same-cycle clear-by-read leaves just the new delta
    logic [7:0] acc_dx_q, acc_dx_d, acc_dy_q, acc_dy_d, dx_base, dy_base;
    logic       mouse_new_q, mouse_new_d, mouse_upd;
    logic       irq_en_q, irq_en_d, irq_q;

    assign mouse_upd = report_i && (typ_i == 2'd2);
    assign dx_base   = clr_dx ? 8'h00 : acc_dx_q;
    assign dy_base   = clr_dy ? 8'h00 : acc_dy_q;

    always_comb begin
        acc_dx_d    = mouse_upd ? sat8(dx_base, mouse_dx_i) : dx_base;
        acc_dy_d    = mouse_upd ? sat8(dy_base, mouse_dy_i) : dy_base;
        mouse_new_d = mouse_upd ? 1'b1 : (clr_dx ? 1'b0 : mouse_new_q);
        irq_en_d    = ctrl_wr ? data_i[0] : irq_en_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cs_q        <= 1'b0;
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            snap_mod_q  <= 8'h00;
            pend_q      <= 1'b0;
            prev_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            acc_dx_q    <= 8'h00;
            acc_dy_q    <= 8'h00;
            mouse_new_q <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            cs_q        <= cs_i;
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            snap_mod_q  <= snap_mod_d;
            pend_q      <= pend_d;
            prev_q      <= prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            acc_dx_q    <= acc_dx_d;
            acc_dy_q    <= acc_dy_d;
            mouse_new_q <= mouse_new_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_en_q & (~empty | mouse_new_q);
        end
    end

    assign irq_o = irq_q;

    always_comb begin
        data_o = 8'h00;
        case (reg_addr_i)
            4'd0: data_o = {irq_en_q, conerr_i, typ_i, ovf_q, mouse_new_q, full, ~empty};
            4'd1: data_o = empty ? 8'h00 : head[7:0];
            4'd2: data_o = empty ? 8'h00 : head[15:8];
            4'd3: data_o = 8'(count_q);
            4'd4: data_o = mouse_btn_i;
            4'd5: data_o = acc_dx_q;
            4'd6: data_o = acc_dy_q;
            default: data_o = 8'h00;
        endcase
    end

endmodule
